de_operand_reg: RTL
===================

Name: de_operand_reg

Overview:
- D/E pipeline register for the five-stage MIPS core; sits directly upstream of the E-stage ALU.
- Captures decoded operands and control from D, and inserts bubbles on stall or flush.
- Applies M/W forwarding so the ALU receives final rs/rt values.
- Freezes under an E-stage hold while keeping held operands coherent with later writebacks.

Parameters:
- DW, 32, data width of pc/operands/immediate
- OPW, 4, alu_op width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  D-stage stalled by hazard unit; E loads bubble
- flush  input  1  kill instruction entering E; E loads bubble
- hold  input  1  E frozen (downstream busy)
- d_valid  input  1  D holds a real instruction
- d_pc  input  DW  D pc
- d_rs_val  input  DW  GRF rs read data
- d_rt_val  input  DW  GRF rt read data
- d_ext  input  DW  extended immediate
- d_alu_op  input  OPW  ALU opcode
- d_rs_addr  input  5  rs index
- d_rt_addr  input  5  rt index
- d_wa  input  5  destination register
- d_we  input  1  register write enable
- m_wa  input  5  M-stage destination
- m_we  input  1  M-stage write enable
- m_data  input  DW  M-stage result
- w_wa  input  5  W-stage destination
- w_we  input  1  W-stage write enable
- w_data  input  DW  W-stage result
- e_valid  output  1  E holds a real instruction
- e_pc  output  DW  E pc
- e_rs  output  DW  forwarded rs to ALU
- e_rt  output  DW  forwarded rt to ALU
- e_ext  output  DW  immediate to ALU
- e_alu_op  output  OPW  opcode to ALU
- e_rs_addr  output  5  latched rs index
- e_rt_addr  output  5  latched rt index
- e_wa  output  5  destination
- e_we  output  1  write enable, forced 0 when !e_valid

Behaviour:
- Reset (reset=0, async): all registers 0; e_valid=0, e_we=0, e_wa=0, e_alu_op=0, e_pc=0, e_rs=e_rt=e_ext=0.
- Per-edge priority: hold > (flush | stall) > load.
- hold=1: every control/addr/pc/ext register keeps its value. The rs/rt data registers reload with the current forwarded e_rs/e_rt, so a value supplied only by M/W forwarding persists after that instruction retires.
- flush=1 or stall=1 (hold=0): bubble. e_valid=0, e_we=0, e_wa=0, e_alu_op=0, e_rs_addr=e_rt_addr=0, data registers 0. e_pc takes d_pc.
- Load (hold=0, flush=0, stall=0): all fields captured from D, with e_valid=d_valid and e_we=d_we&d_valid.
- Capture-time W bypass: if w_we && w_wa!=0 && w_wa==d_rs_addr, the rs register takes w_data instead of d_rs_val. rt is handled the same way. This covers same-cycle GRF write/read.
- Combinational forwarding for e_rs:
  - m_data if m_we && m_wa!=0 && m_wa==e_rs_addr;
  - else w_data if w_we && w_wa!=0 && w_wa==e_rs_addr;
  - else the latched value.
  - e_rt uses the same rule with e_rt_addr.
  - M has priority over W.
- Register $0 is never forwarded; an index of 0 always yields the latched value, which is 0 from the GRF.
- Latency: one cycle D→E. Forwarding adds zero cycles.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro DE_BUBBLE_CNT_EN.
- Defined:
  - extra output bubble_cnt (32-bit), reset 0.
  - Increments by 1 on each edge where hold=0 and (stall|flush)=1.
  - Wraps 0xFFFFFFFF→0.
  - hold cycles are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with reset=0 mid-stream (e_valid=1, e_we=1) → all outputs 0 immediately, without waiting for a clock edge.
- Load d_rs_addr=8, d_rs_val=5, d_alu_op=0, d_valid=1 → next cycle e_rs=5, e_alu_op=0, e_valid=1. Then m_we=1, m_wa=8, m_data=0x1234 → e_rs=0x1234 the same cycle. Adding w_wa=8, w_data=0x9999 → e_rs stays 0x1234 (M wins).
- Forwarding to $0: e_rt_addr=0, m_we=1, m_wa=0, m_data=7 → e_rt=0.
- hold=1 with e_rs_addr=9 and M forwarding 0xAB for one cycle; M then changes to m_wa=3 → e_rs remains 0xAB while hold persists, and all other fields stay unchanged.
- stall=1 → next cycle e_valid=0, e_we=0, e_wa=0. With DE_BUBBLE_CNT_EN, bubble_cnt increments 0→1. flush=1 together with hold=1 → no change and no count.
- Capture bypass: d_rs_addr=4 with w_we=1, w_wa=4, w_data=0x55 at the load edge → latched rs=0x55. Next cycle, with no forwarding active, e_rs=0x55.

Source files
------------

// File: rtl/de_operand_reg.sv
// ---------------------------------------------------------------------------
// de_operand_reg
//   D/E pipeline register of the five-stage MIPS core. It sits directly in
//   front of the E-stage ALU.
//
//   It captures the decoded operands and control from D. On a stall or a
//   flush it inserts a bubble. It forwards M/W results so the ALU sees the
//   final rs/rt values. Under an E-stage hold it freezes, while the held
//   rs/rt operands keep absorbing any forwarded value.
//
//   Per-edge priority: hold > (flush | stall) > load.
//
// Optional feature (macro DE_BUBBLE_CNT_EN):
//   When the macro is defined, the block adds a 32-bit output bubble_cnt.
//   The counter increments on every edge that inserts a bubble (hold=0 and
//   stall|flush=1) and wraps from 0xFFFFFFFF to 0.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   stall, flush, hold  pipeline control from the hazard unit / downstream
//   d_*                 decoded instruction fields from D
//   m_wa/m_we/m_data    M-stage writeback (forwarding source, priority 1)
//   w_wa/w_we/w_data    W-stage writeback (forwarding source, priority 2)
//   e_*                 operands and control presented to the E stage
//   bubble_cnt          bubble counter (only with DE_BUBBLE_CNT_EN)
// ---------------------------------------------------------------------------
module de_operand_reg #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  input  logic           hold,
  input  logic           d_valid,
  input  logic [DW-1:0]  d_pc,
  input  logic [DW-1:0]  d_rs_val,
  input  logic [DW-1:0]  d_rt_val,
  input  logic [DW-1:0]  d_ext,
  input  logic [OPW-1:0] d_alu_op,
  input  logic [4:0]     d_rs_addr,
  input  logic [4:0]     d_rt_addr,
  input  logic [4:0]     d_wa,
  input  logic           d_we,
  input  logic [4:0]     m_wa,
  input  logic           m_we,
  input  logic [DW-1:0]  m_data,
  input  logic [4:0]     w_wa,
  input  logic           w_we,
  input  logic [DW-1:0]  w_data,
`ifdef DE_BUBBLE_CNT_EN
  output logic [31:0]    bubble_cnt,
`endif
  output logic           e_valid,
  output logic [DW-1:0]  e_pc,
  output logic [DW-1:0]  e_rs,
  output logic [DW-1:0]  e_rt,
  output logic [DW-1:0]  e_ext,
  output logic [OPW-1:0] e_alu_op,
  output logic [4:0]     e_rs_addr,
  output logic [4:0]     e_rt_addr,
  output logic [4:0]     e_wa,
  output logic           e_we
);

  logic           r_valid;
  logic [DW-1:0]  r_pc;
  logic [DW-1:0]  r_rs;
  logic [DW-1:0]  r_rt;
  logic [DW-1:0]  r_ext;
  logic [OPW-1:0] r_alu_op;
  logic [4:0]     r_rs_addr;
  logic [4:0]     r_rt_addr;
  logic [4:0]     r_wa;
  logic           r_we;

  logic [DW-1:0]  w_fwd_rs;
  logic [DW-1:0]  w_fwd_rt;
  logic [DW-1:0]  w_cap_rs;
  logic [DW-1:0]  w_cap_rt;
  logic           w_bubble;

  // A bubble is inserted only when E is not frozen.
  assign w_bubble = ~hold & (stall | flush);

  // Forwarding into E: M beats W, and register $0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rs;
    w_fwd_rt = r_rt;
    if (m_we && (m_wa != 5'd0) && (m_wa == r_rs_addr)) begin
      w_fwd_rs = m_data;
    end else if (w_we && (w_wa != 5'd0) && (w_wa == r_rs_addr)) begin
      w_fwd_rs = w_data;
    end else begin
      w_fwd_rs = r_rs;
    end
    if (m_we && (m_wa != 5'd0) && (m_wa == r_rt_addr)) begin
      w_fwd_rt = m_data;
    end else if (w_we && (w_wa != 5'd0) && (w_wa == r_rt_addr)) begin
      w_fwd_rt = w_data;
    end else begin
      w_fwd_rt = r_rt;
    end
  end

  // Capture-time W bypass: covers a GRF write and read in the same cycle.
  always_comb begin
    w_cap_rs = d_rs_val;
    w_cap_rt = d_rt_val;
    if (w_we && (w_wa != 5'd0) && (w_wa == d_rs_addr)) begin
      w_cap_rs = w_data;
    end else begin
      w_cap_rs = d_rs_val;
    end
    if (w_we && (w_wa != 5'd0) && (w_wa == d_rt_addr)) begin
      w_cap_rt = w_data;
    end else begin
      w_cap_rt = d_rt_val;
    end
  end

  // D/E pipeline register with hold / bubble / load priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_ext     <= '0;
      r_alu_op  <= '0;
      r_rs_addr <= 5'd0;
      r_rt_addr <= 5'd0;
      r_wa      <= 5'd0;
      r_we      <= 1'b0;
    end else if (hold) begin
      // Fold any forwarded value into the operand registers. The operand
      // then survives after the producing instruction has retired.
      r_rs <= w_fwd_rs;
      r_rt <= w_fwd_rt;
    end else if (stall || flush) begin
      r_valid   <= 1'b0;
      r_pc      <= d_pc;
      r_rs      <= '0;
      r_rt      <= '0;
      r_ext     <= '0;
      r_alu_op  <= '0;
      r_rs_addr <= 5'd0;
      r_rt_addr <= 5'd0;
      r_wa      <= 5'd0;
      r_we      <= 1'b0;
    end else begin
      r_valid   <= d_valid;
      r_pc      <= d_pc;
      r_rs      <= w_cap_rs;
      r_rt      <= w_cap_rt;
      r_ext     <= d_ext;
      r_alu_op  <= d_alu_op;
      r_rs_addr <= d_rs_addr;
      r_rt_addr <= d_rt_addr;
      r_wa      <= d_wa;
      r_we      <= d_we & d_valid;
    end
  end

`ifdef DE_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Bubble counter; frozen cycles are not counted, and the count wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_bubble;
  assign w_unused_bubble = w_bubble;
`endif

  assign e_valid   = r_valid;
  assign e_pc      = r_pc;
  assign e_rs      = w_fwd_rs;
  assign e_rt      = w_fwd_rt;
  assign e_ext     = r_ext;
  assign e_alu_op  = r_alu_op;
  assign e_rs_addr = r_rs_addr;
  assign e_rt_addr = r_rt_addr;
  assign e_wa      = r_wa;
  assign e_we      = r_we & r_valid;

endmodule
